// File: rtl/register_file_scoreboard_if.sv
// Bus bundle for register_file_scoreboard: two read ports, the writeback
// port, the issue-stage reservation handshake, the busy count and the
// debug tap. Parameters must match the ones given to the register file.
interface register_file_scoreboard_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
);
  logic [ADDR_WIDTH-1:0] readAddress1;
  logic [ADDR_WIDTH-1:0] readAddress2;
  logic [DATA_WIDTH-1:0] readData1;
  logic [DATA_WIDTH-1:0] readData2;
  logic                  readBusy1;
  logic                  readBusy2;
  logic                  writeEnable;
  logic [ADDR_WIDTH-1:0] writeAddress;
  logic [DATA_WIDTH-1:0] writeData;
  logic                  reserveEnable;
  logic [ADDR_WIDTH-1:0] reserveAddress;
  logic                  reserveGrant;
  logic [ADDR_WIDTH:0]   busyCount;
  logic [ADDR_WIDTH-1:0] debugAddress;
  logic [DATA_WIDTH-1:0] debugData;

  // Register-file side.
  modport slave (
    input  readAddress1, readAddress2,
    output readData1, readData2, readBusy1, readBusy2,
    input  writeEnable, writeAddress, writeData,
    input  reserveEnable, reserveAddress,
    output reserveGrant, busyCount,
    input  debugAddress,
    output debugData
  );

  // Decode/issue and writeback side.
  modport master (
    output readAddress1, readAddress2,
    input  readData1, readData2, readBusy1, readBusy2,
    output writeEnable, writeAddress, writeData,
    output reserveEnable, reserveAddress,
    input  reserveGrant, busyCount,
    output debugAddress,
    input  debugData
  );
endinterface

// File: rtl/register_file_scoreboard.sv
// Parametrised register file with two combinational read ports, one
// synchronous write port, optional write-to-read bypass and a per-register
// busy scoreboard. Register 0 is hardwired to zero and is never busy.
//
// Reservation handshake: reserveEnable is the request (valid) and
// reserveGrant the combinational acceptance (ready). A reservation is taken
// exactly on a rising edge where both are high; a refused request changes
// nothing and the issue stage holds reserveAddress and retries.
module register_file_scoreboard #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter bit BYPASS     = 1'b1
) (
  input logic                        clock,
  input logic                        resetN,
  register_file_scoreboard_if.slave  bus
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] COUNT_ONE = 1;

  logic [DATA_WIDTH-1:0] regs [DEPTH];
  logic [DEPTH-1:0]      busy;
  logic [DEPTH-1:0]      busy_next;
  logic [ADDR_WIDTH:0]   busy_count;
  logic                  write_hit;
  logic                  grant;
  logic                  reserve_hit;
  logic                  count_inc;
  logic                  count_dec;

  // A write to register 0 is dropped, so it never counts as a hit.
  assign write_hit = bus.writeEnable && (bus.writeAddress != '0);

  // A same-cycle write to the requested register frees it, so the new
  // producer may reserve it in that very cycle.
  assign grant = bus.reserveEnable &&
                 ((bus.reserveAddress == '0) ||
                  !busy[bus.reserveAddress] ||
                  (bus.writeEnable && (bus.writeAddress == bus.reserveAddress)));

  // Reserving register 0 is granted but leaves no trace.
  assign reserve_hit = grant && (bus.reserveAddress != '0);

  // Count moves only on real 0->1 / 1->0 transitions of busy bits; a write
  // and reserve to the same busy register leaves it busy and the count flat.
  assign count_inc = reserve_hit && !busy[bus.reserveAddress];
  assign count_dec = write_hit && busy[bus.writeAddress] &&
                     !(reserve_hit && (bus.reserveAddress == bus.writeAddress));

  // Next busy vector: writeback clears first, reservation sets last so the
  // new producer wins a same-address collision.
  always_comb begin
    busy_next = busy;
    if (write_hit)   busy_next[bus.writeAddress]   = 1'b0;
    if (reserve_hit) busy_next[bus.reserveAddress] = 1'b1;
  end

  // Register storage; reset clears every entry.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (write_hit) begin
      regs[bus.writeAddress] <= bus.writeData;
    end
  end

  // Busy scoreboard and its population count.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      busy       <= '0;
      busy_count <= '0;
    end else begin
      busy <= busy_next;
      case ({count_inc, count_dec})
        2'b10:   busy_count <= busy_count + COUNT_ONE;
        2'b01:   busy_count <= busy_count - COUNT_ONE;
        default: busy_count <= busy_count;
      endcase
    end
  end

  // Read port 1: stored value, or the in-flight write when bypassing.
  always_comb begin
    bus.readData1 = '0;
    bus.readBusy1 = 1'b0;
    if (resetN) begin
      if (BYPASS && write_hit && (bus.writeAddress == bus.readAddress1)) begin
        bus.readData1 = bus.writeData;
        bus.readBusy1 = 1'b0;
      end else begin
        bus.readData1 = regs[bus.readAddress1];
        bus.readBusy1 = busy[bus.readAddress1];
      end
    end
  end

  // Read port 2: same behaviour as port 1.
  always_comb begin
    bus.readData2 = '0;
    bus.readBusy2 = 1'b0;
    if (resetN) begin
      if (BYPASS && write_hit && (bus.writeAddress == bus.readAddress2)) begin
        bus.readData2 = bus.writeData;
        bus.readBusy2 = 1'b0;
      end else begin
        bus.readData2 = regs[bus.readAddress2];
        bus.readBusy2 = busy[bus.readAddress2];
      end
    end
  end

  assign bus.reserveGrant = grant;
  assign bus.busyCount    = busy_count;
  // Debug tap always shows committed storage, never the bypass path.
  assign bus.debugData    = regs[bus.debugAddress];

endmodule
